// File: rtl/subleq_core.sv
// subleq_core: single-issue SUBLEQ core ("subleq a,b,c") on one req/ack memory port.
// Every instruction is four accesses in order: fetch pc, read a, read b, write b.
module subleq_core #(
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           DATA_WIDTH  = 24,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  // Memory handshake: mem_req/mem_we/mem_addr/mem_wdata come straight from
  // registers and hold until a cycle with mem_req & mem_ack, which completes
  // the access; a follow-on access is presented the next cycle with mem_req
  // kept high. Read data is taken only in the ack cycle of a read.
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic                   mem_ack,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic [2:0]             dbg_state
);

  localparam int unsigned A = ADDR_WIDTH;

  if (DATA_WIDTH < 3 * ADDR_WIDTH) begin : g_width_check
    $error("subleq_core: DATA_WIDTH must be at least 3*ADDR_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_RD_A  = 3'd2,
    S_RD_B  = 3'd3,
    S_WR_B  = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [A-1:0]           pc_q, pc_d;
  logic                   halted_q, halted_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   req_q, req_d;
  logic                   we_q, we_d;
  logic [A-1:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  // Only the b and c fields are kept: a is used straight from the fetch data.
  logic [2*A-1:0]         ir_q, ir_d;
  logic [DATA_WIDTH-1:0]  opa_q, opa_d;
  logic [DATA_WIDTH-1:0]  opb_q, opb_d;

  logic [A-1:0]           ir_b, ir_c;
  logic [DATA_WIDTH-1:0]  res;
  logic                   res_le_zero;
  logic [A-1:0]           pc_inc, pc_next;

  assign ir_b        = ir_q[2*A-1:A];
  assign ir_c        = ir_q[A-1:0];
  assign res         = opb_q - opa_q;
  assign res_le_zero = res[DATA_WIDTH-1] | (res == '0);
  assign pc_inc      = pc_q + ADDR_WIDTH'(1);
  assign pc_next     = res_le_zero ? ir_c : pc_inc;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    count_d  = count_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ir_d     = ir_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = pc_q;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata[2*A-1:0];
          addr_d  = mem_rdata[3*A-1:2*A];
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        if (mem_ack) begin
          opa_d   = mem_rdata;
          addr_d  = ir_b;
          state_d = S_RD_B;
        end
      end
      S_RD_B: begin
        if (mem_ack) begin
          opb_d   = mem_rdata;
          wdata_d = mem_rdata - opa_q;
          we_d    = 1'b1;
          state_d = S_WR_B;
        end
      end
      S_WR_B: begin
        if (mem_ack) begin
          count_d = count_q + COUNT_WIDTH'(1);
          pc_d    = pc_next;
          we_d    = 1'b0;
          wdata_d = '0;
          // A taken branch back onto itself can never make progress: stop.
          if (res_le_zero && (ir_c == pc_q)) begin
            halted_d = 1'b1;
            req_d    = 1'b0;
            state_d  = S_HALT;
          end else if (run) begin
            req_d   = 1'b1;
            addr_d  = pc_next;
            state_d = S_FETCH;
          end else begin
            req_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_HALT: begin
        req_d = 1'b0;
        we_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      count_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ir_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      count_q  <= count_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ir_q     <= ir_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign instr_count = count_q;
  assign dbg_state   = 3'(state_q);

endmodule

// File: tb/tb_subleq_core.sv
// Bench for subleq_core: behavioural memory with programmable ack latency,
// a sequential SUBLEQ reference model and an expected-write queue.
module tb_subleq_core;
  localparam int AW = 8;
  localparam int DW = 24;
  localparam int CW = 32;

  logic          clk;
  logic          rst;
  logic          run;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          halted;
  logic [CW-1:0] instr_count;
  logic [2:0]    dbg_state;

  subleq_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(8'd0), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc(pc), .halted(halted), .instr_count(instr_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // ---------------- memory model ----------------
  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] ref_mem [0:255];
  int wait_cnt    = 0;
  int fixed_delay = 0;
  int rand_delay  = 0;
  bit rand_mode   = 0;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (wait_cnt >= (rand_mode ? rand_delay : fixed_delay));

  always @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 0;
    end else if (mem_req && mem_ack) begin
      wait_cnt   <= 0;
      rand_delay <= int'($urandom_range(0, 3));
      if (mem_we) mem[mem_addr] = mem_wdata;
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];
  bit sb_en = 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  bit                hold_v = 0;
  logic [AW+DW:0]    hold_bus;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 0;
    end else begin
      if (hold_v) check("hold_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, hold_bus});
      hold_v   = mem_req && !mem_ack;
      hold_bus = {mem_we, mem_addr, mem_wdata};
      if (sb_en && mem_req && mem_ack && mem_we) begin
        check("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("wr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  logic [AW-1:0] ref_pc;
  logic [CW-1:0] ref_count;
  bit            ref_halted;

  function automatic logic [DW-1:0] enc(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                        input logic [AW-1:0] c);
    return {a, b, c};
  endfunction

  task automatic put(input int addr, input logic [DW-1:0] d);
    mem[addr]     = d;
    ref_mem[addr] = d;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) put(i, '0);
  endtask

  task automatic model_step();
    logic [DW-1:0] w, res;
    logic [AW-1:0] a, b, c;
    w = ref_mem[ref_pc];
    a = w[23:16];
    b = w[15:8];
    c = w[7:0];
    res = ref_mem[b] - ref_mem[a];
    ref_mem[b] = res;
    exp_q.push_back({b, res});
    ref_count = ref_count + 1;
    if ($signed(res) <= 0) begin
      if (c == ref_pc) ref_halted = 1;
      ref_pc = c;
    end else begin
      ref_pc = ref_pc + 8'd1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    run = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    ref_pc     = '0;
    ref_count  = '0;
    ref_halted = 0;
    exp_q.delete();
  endtask

  // Runs one instruction from IDLE; run is held for run_hold cycles.
  task automatic step(input string tag, input int run_hold, input int exp_cyc);
    int cyc;
    int guard;
    model_step();
    @(negedge clk);
    run   = 1;
    cyc   = 0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (guard >= run_hold) run = 0;
      if (mem_req) cyc++;
    end while ((mem_req || cyc == 0) && guard < 400);
    check({tag, "_timeout"}, guard < 400, 1);
    check({tag, "_pc"}, pc, ref_pc);
    check({tag, "_count"}, instr_count, ref_count);
    check({tag, "_halted"}, halted, ref_halted);
    if (exp_cyc >= 0) check({tag, "_cycles"}, cyc, exp_cyc);
  endtask

  task automatic load_t2();
    clear_mem();
    put(0, enc(8'd10, 8'd11, 8'd5));
    put(10, 24'd3);
    put(11, 24'd7);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int req_seen;
    int mism;
    rst = 1;
    run = 0;
    ref_pc = '0; ref_count = '0; ref_halted = 0;
    clear_mem();
    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    check("rst_count", instr_count, 0);
    rst = 0;

    // basic instruction, zero-wait memory
    load_t2();
    do_reset();
    step("t2", 1, 4);
    check("t2_mem11", mem[11], 24'd4);
    check("t2_pc_const", pc, 8'd1);

    // result zero branches
    load_t2();
    put(11, 24'd3);
    do_reset();
    step("t3a", 1, 4);
    check("t3a_mem11", mem[11], 24'd0);
    check("t3a_pc_const", pc, 8'd5);

    // negative result branches (signed compare)
    load_t2();
    put(10, 24'd5);
    put(11, 24'd3);
    do_reset();
    step("t3b", 1, 4);
    check("t3b_mem11", mem[11], 24'hFFFFFE);
    check("t3b_pc_const", pc, 8'd5);

    // self-loop halt with a==b
    clear_mem();
    put(0, enc(8'd30, 8'd31, 8'd2));
    put(30, 24'd1);
    put(31, 24'd1);
    put(2, enc(8'd20, 8'd20, 8'd2));
    put(20, 24'd9);
    do_reset();
    step("t4a", 1, 4);
    step("t4b", 1, 4);
    check("t4_mem20", mem[20], 24'd0);
    check("t4_halted_const", halted, 1);
    run = 1;
    req_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (mem_req) req_seen++;
    end
    run = 0;
    check("t4_no_req", req_seen, 0);
    check("t4_pc_hold", pc, 8'd2);
    check("t4_halted_hold", halted, 1);

    // 3 wait states per access
    fixed_delay = 3;
    load_t2();
    do_reset();
    step("t5", 1, 16);
    check("t5_mem11", mem[11], 24'd4);
    check("t5_pc_const", pc, 8'd1);
    fixed_delay = 0;

    // drop run during RD_A
    load_t2();
    do_reset();
    step("t6a", 2, 4);
    req_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_req) req_seen++;
    end
    check("t6a_idle", req_seen, 0);
    check("t6a_pc_const", pc, 8'd1);

    // reset during RD_B
    load_t2();
    do_reset();
    @(negedge clk);
    run = 1;
    repeat (3) @(negedge clk);
    check("t6b_rdb_access", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'd11});
    #1 rst = 1;
    #1;
    check("t6b_req_async", mem_req, 0);
    check("t6b_we", mem_we, 0);
    check("t6b_pc", pc, 0);
    check("t6b_count", instr_count, 0);
    run = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    check("t6b_mem11_kept", mem[11], 24'd7);
    ref_pc = '0; ref_count = '0; ref_halted = 0;
    exp_q.delete();
    step("t6c", 1, 4);
    check("t6c_mem11", mem[11], 24'd4);

    // random programs with random ack latency
    rand_mode = 1;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 256; i++) put(i, DW'($urandom()));
      do_reset();
      for (int s = 0; s < 30 && !ref_halted; s++) step("rnd", 1, -1);
      mism = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
      check("rnd_mem_image", mism, 0);
      check("rnd_q_drained", exp_q.size(), 0);
    end
    rand_mode = 0;

    // reset pulse while running freely
    for (int i = 0; i < 256; i++) put(i, DW'($urandom()));
    do_reset();
    sb_en = 0;
    @(negedge clk);
    run = 1;
    repeat (13) @(negedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    check("t1_req", mem_req, 0);
    check("t1_pc", pc, 0);
    check("t1_halted", halted, 0);
    check("t1_count", instr_count, 0);
    run = 0;
    @(negedge clk);
    rst = 0;
    sb_en = 1;
    exp_q.delete();

    check("final_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
